reg_decode_stage: RTL

REG_DECODE_STAGE -- requirements
Module: reg_decode_stage

---
 rtl/reg_decode_stage.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/reg_decode_stage.sv
// Register-file decode stage: clears its register file after reset, then decodes
// RV32 instructions into registered operands/immediates with load-use stall and write forwarding.
module reg_decode_stage #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_valid,
  input  logic [31:0]     inst,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            ready,
  output logic            stall,
  output logic            out_valid,
  output logic [XLEN-1:0] out_rs1,
  output logic [XLEN-1:0] out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic [AW-1:0]   out_rd
);

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_STOR = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_AUI  = 7'b0010111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_REG  = 7'b0110011;

  state_t            state, state_next;
  logic [AW-1:0]     cnt;
  logic [XLEN-1:0]   regs [NREG];
  logic [NREG-1:0]   pend;

  logic [6:0]        opcode;
  logic [AW-1:0]     rs1, rs2, rd;
  logic [31:0]       imm32;
  logic              use_rs1, use_rs2, is_load;
  logic              wb_act, hit1, hit2, accept;
  logic [XLEN-1:0]   rs1_val, rs2_val;
  logic              unused_funct3;

  // Register fields beyond the implemented file alias to x0.
  function automatic logic [AW-1:0] map_idx(input logic [4:0] f);
    if (32'(f) >= NREG) begin
      return '0;
    end else begin
      return f[AW-1:0];
    end
  endfunction

  assign opcode        = inst[6:0];
  assign rs1           = map_idx(inst[19:15]);
  assign rs2           = map_idx(inst[24:20]);
  assign rd            = map_idx(inst[11:7]);
  assign is_load       = (opcode == OP_LOAD);
  assign unused_funct3 = ^inst[14:12];

  assign ready  = (state == RUN);
  assign wb_act = wb_en & ready;
  assign hit1   = (BYPASS != 0) && wb_act && (wb_addr == rs1);
  assign hit2   = (BYPASS != 0) && wb_act && (wb_addr == rs2);
  assign stall  = inst_valid & ready &
                  ((use_rs1 & pend[rs1] & ~hit1) | (use_rs2 & pend[rs2] & ~hit2));
  assign accept = inst_valid & ready & ~stall;

  always_comb begin
    imm32   = 32'd0;
    use_rs1 = 1'b1;
    use_rs2 = 1'b0;
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR: imm32 = {{20{inst[31]}}, inst[31:20]};
      OP_STOR: begin
        imm32   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        use_rs2 = 1'b1;
      end
      OP_BR: begin
        imm32   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        use_rs2 = 1'b1;
      end
      OP_LUI, OP_AUI: begin
        imm32   = {inst[31:12], 12'd0};
        use_rs1 = 1'b0;
      end
      OP_JAL: begin
        imm32   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        use_rs1 = 1'b0;
      end
      OP_REG:  use_rs2 = 1'b1;
      default: imm32 = 32'd0;
    endcase
  end

  // Operand reads; x0 is hard zero and a concurrent writeback may be forwarded.
  always_comb begin
    if (rs1 == '0) begin
      rs1_val = '0;
    end else if (hit1) begin
      rs1_val = wb_data;
    end else begin
      rs1_val = regs[rs1];
    end
    if (rs2 == '0) begin
      rs2_val = '0;
    end else if (hit2) begin
      rs2_val = wb_data;
    end else begin
      rs2_val = regs[rs2];
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      CLEAR: begin
        if (cnt == LAST_IDX) begin
          state_next = RUN;
        end else begin
          state_next = CLEAR;
        end
      end
      RUN:     state_next = RUN;
      default: state_next = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state == CLEAR) begin
        cnt <= cnt + AW'(1);
      end
    end
  end

  // The clear sequence owns the write port until RUN.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      regs[cnt] <= '0;
    end else if (wb_en && (wb_addr != '0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Later assignment wins, so a same-cycle load set beats a writeback clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
    end else if (ready) begin
      if (wb_en) begin
        pend[wb_addr] <= 1'b0;
      end
      if (accept && is_load && (rd != '0)) begin
        pend[rd] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_rs1   <= '0;
      out_rs2   <= '0;
      out_imm   <= '0;
      out_rd    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_rs1   <= rs1_val;
      out_rs2   <= rs2_val;
      out_imm   <= XLEN'($signed(imm32));
      out_rd    <= rd;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule
